// File: rtl/cp_inserter.sv
// Cyclic-prefix inserter: ping-pong buffers IFFT frames and replays each one
// as its last CP_LEN samples followed by the full frame.
//
// state   | meaning
// S_IDLE  | no frame in playout, waiting for buffer rd_sel to fill
// S_CP    | fetching prefix samples buffer[FFT_LEN-CP_LEN .. FFT_LEN-1]
// S_BODY  | fetching body samples buffer[0 .. FFT_LEN-1]
// S_DRAIN | last body sample on the output, waiting for it to be accepted
module cp_inserter #(
   parameter int FFT_LEN = 16,
   parameter int CP_LEN  = 4,
   parameter int DW      = 32
) (
   input  logic          aclk,
   input  logic          reset,
   input  logic [DW-1:0] s_data_in,
   input  logic          s_dvalid,
   input  logic          s_dlast,
   output logic          s_dready,
   output logic [DW-1:0] m_data_out,
   output logic          m_dvalid,
   output logic          m_dlast,
   input  logic          m_dready,
   output logic          frame_err
);

   localparam int AW = $clog2(FFT_LEN);
   localparam logic [AW-1:0] START = AW'(FFT_LEN - CP_LEN);
   localparam logic [AW-1:0] LAST  = AW'(FFT_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_CP, S_BODY, S_DRAIN} rd_state_t;

   logic [DW-1:0] mem [2][FFT_LEN];
   logic [1:0]    full, full_n;
   logic          wr_sel, wr_sel_n;
   logic [AW-1:0] wr_ptr, wr_ptr_n;
   logic          err_n;
   logic          s_acc;
   logic          rel;
   logic          adv;

   rd_state_t     state;
   logic          rd_sel;
   logic [AW-1:0] rd_ptr;

   assign s_acc = s_dvalid && s_dready;
   assign rel   = (state == S_DRAIN) && m_dready;
   assign adv   = !m_dvalid || m_dready;

   // Read-side release and write-side completion always touch different
   // buffers, so both updates can land in the same cycle.
   always_comb begin
      full_n   = full;
      wr_sel_n = wr_sel;
      wr_ptr_n = wr_ptr;
      err_n    = 1'b0;
      if (rel) full_n[rd_sel] = 1'b0;
      if (s_acc) begin
         if (wr_ptr == LAST) begin
            full_n[wr_sel] = 1'b1;
            wr_sel_n       = ~wr_sel;
            wr_ptr_n       = '0;
            err_n          = !s_dlast;
         end else if (s_dlast) begin
            wr_ptr_n = '0;
            err_n    = 1'b1;
         end else begin
            wr_ptr_n = wr_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         full      <= '0;
         wr_sel    <= 1'b0;
         wr_ptr    <= '0;
         s_dready  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         full      <= full_n;
         wr_sel    <= wr_sel_n;
         wr_ptr    <= wr_ptr_n;
         s_dready  <= !full_n[wr_sel_n];
         frame_err <= err_n;
      end
   end

   always_ff @(posedge aclk) begin
      if (s_acc) mem[wr_sel][wr_ptr] <= s_data_in;
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         state      <= S_IDLE;
         rd_sel     <= 1'b0;
         rd_ptr     <= '0;
         m_data_out <= '0;
         m_dvalid   <= 1'b0;
         m_dlast    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (full[rd_sel]) begin
                  rd_ptr <= START;
                  state  <= (CP_LEN == 0) ? S_BODY : S_CP;
               end
            end
            S_CP: begin
               if (adv) begin
                  m_data_out <= mem[rd_sel][rd_ptr];
                  m_dvalid   <= 1'b1;
                  m_dlast    <= 1'b0;
                  rd_ptr     <= rd_ptr + 1'b1;
                  if (rd_ptr == LAST) state <= S_BODY;
               end
            end
            S_BODY: begin
               if (adv) begin
                  m_data_out <= mem[rd_sel][rd_ptr];
                  m_dvalid   <= 1'b1;
                  m_dlast    <= (rd_ptr == LAST);
                  rd_ptr     <= rd_ptr + 1'b1;
                  if (rd_ptr == LAST) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (m_dready) begin
                  rd_sel  <= ~rd_sel;
                  m_dlast <= 1'b0;
                  // Start the next symbol on the same edge so back-to-back
                  // symbols stream without a bubble.
                  if (full[~rd_sel]) begin
                     m_data_out <= mem[~rd_sel][START];
                     m_dvalid   <= 1'b1;
                     rd_ptr     <= START + 1'b1;
                     state      <= (CP_LEN <= 1) ? S_BODY : S_CP;
                  end else begin
                     m_dvalid <= 1'b0;
                     state    <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cp_inserter.sv
// Directed bench for cp_inserter: a CP_LEN=4 instance plus a CP_LEN=0 instance
// sharing the same input stimulus.
module tb_cp_inserter;

   localparam int FFT_LEN = 16;
   localparam int CP_LEN  = 4;

   logic        aclk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] s_data_in = '0;
   logic        s_dvalid = 1'b0;
   logic        s_dlast = 1'b0;
   logic        m_dready = 1'b0;
   logic        s_dready, m_dvalid, m_dlast, frame_err;
   logic [31:0] m_data_out;
   logic        s0_dready, m0_dvalid, m0_dlast, frame0_err;
   logic [31:0] m0_data_out;

   cp_inserter #(.FFT_LEN(FFT_LEN), .CP_LEN(CP_LEN), .DW(32)) dut (
      .aclk(aclk), .reset(reset),
      .s_data_in(s_data_in), .s_dvalid(s_dvalid), .s_dlast(s_dlast), .s_dready(s_dready),
      .m_data_out(m_data_out), .m_dvalid(m_dvalid), .m_dlast(m_dlast), .m_dready(m_dready),
      .frame_err(frame_err)
   );

   cp_inserter #(.FFT_LEN(FFT_LEN), .CP_LEN(0), .DW(32)) dut0 (
      .aclk(aclk), .reset(reset),
      .s_data_in(s_data_in), .s_dvalid(s_dvalid), .s_dlast(s_dlast), .s_dready(s0_dready),
      .m_data_out(m0_data_out), .m_dvalid(m0_dvalid), .m_dlast(m0_dlast), .m_dready(m_dready),
      .frame_err(frame0_err)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   logic [31:0] oq[$];
   logic        lq[$];
   logic [31:0] oq0[$];
   logic        lq0[$];
   logic [31:0] eq[$];
   logic        el[$];
   logic [31:0] eq0[$];
   logic        el0[$];

   int          first_v = -1;
   int          first_x = -1;
   int          last_x = -1;
   int          err_cnt = 0;
   bit          saw_bp = 1'b0;
   bit          stall_prev = 1'b0;
   logic [31:0] held_d = '0;
   logic        held_l = 1'b0;

   always @(negedge aclk) begin
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk_val("stall_valid", 32'(m_dvalid), 32'd1);
            chk_val("stall_data", m_data_out, held_d);
            chk_val("stall_last", 32'(m_dlast), 32'(held_l));
         end
         if (m_dvalid && first_v < 0) first_v = cyc;
         if (m_dvalid && m_dready) begin
            oq.push_back(m_data_out);
            lq.push_back(m_dlast);
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
         end
         if (m0_dvalid && m_dready) begin
            oq0.push_back(m0_data_out);
            lq0.push_back(m0_dlast);
         end
         if (frame_err) err_cnt++;
         if (s_dvalid && !s_dready) saw_bp = 1'b1;
         stall_prev = m_dvalid && !m_dready;
         held_d     = m_data_out;
         held_l     = m_dlast;
      end
   end

   task automatic clear_mon();
      oq.delete(); lq.delete(); oq0.delete(); lq0.delete();
      eq.delete(); el.delete(); eq0.delete(); el0.delete();
      first_v = -1; first_x = -1; last_x = -1;
      err_cnt = 0; saw_bp = 1'b0;
   endtask

   // Expected symbol: last cp samples of the frame, then the whole frame.
   task automatic add_exp(input logic [31:0] base, input bit cp0);
      int cp;
      cp = cp0 ? 0 : CP_LEN;
      for (int k = FFT_LEN - cp; k < FFT_LEN; k++) begin
         if (cp0) begin eq0.push_back(base + 32'(k)); el0.push_back(1'b0); end
         else     begin eq.push_back(base + 32'(k));  el.push_back(1'b0);  end
      end
      for (int k = 0; k < FFT_LEN; k++) begin
         if (cp0) begin eq0.push_back(base + 32'(k)); el0.push_back(k == FFT_LEN - 1); end
         else     begin eq.push_back(base + 32'(k));  el.push_back(k == FFT_LEN - 1);  end
      end
   endtask

   task automatic push(input logic [31:0] d, input logic l);
      int t;
      s_data_in = d;
      s_dlast   = l;
      s_dvalid  = 1'b1;
      t = 0;
      @(negedge aclk);
      while (!s_dready && t < 2000) begin
         @(negedge aclk);
         t++;
      end
      if (!s_dready) chk_val("push_ready", 32'(s_dready), 32'd1);
      @(posedge aclk);
      #1;
      s_dvalid = 1'b0;
      s_dlast  = 1'b0;
   endtask

   task automatic push_frame(input logic [31:0] base, input int n, input bit with_last);
      for (int i = 0; i < n; i++) push(base + 32'(i), with_last && (i == n - 1));
   endtask

   task automatic wait_out(input int n, input int budget);
      int t;
      t = 0;
      while (oq.size() < n && t < budget) begin
         @(posedge aclk);
         #2;
         t++;
      end
      chk_val("out_count", 32'(oq.size()), 32'(n));
   endtask

   task automatic cmp_q(input string tag, input logic [31:0] gd[$], input logic gl[$],
                        input logic [31:0] ed[$], input logic xl[$]);
      chk_val({tag, "_len"}, 32'(gd.size()), 32'(ed.size()));
      for (int i = 0; i < ed.size() && i < gd.size(); i++) begin
         chk_val($sformatf("%s_data[%0d]", tag, i), gd[i], ed[i]);
         chk_val($sformatf("%s_last[%0d]", tag, i), 32'(gl[i]), 32'(xl[i]));
      end
   endtask

   bit done;
   int hs;
   int t;

   initial begin
      // Reset values
      repeat (3) @(posedge aclk);
      #1;
      chk_val("rst_s_dready", 32'(s_dready), 32'd0);
      chk_val("rst_m_dvalid", 32'(m_dvalid), 32'd0);
      chk_val("rst_m_data", m_data_out, 32'd0);
      chk_val("rst_m_dlast", 32'(m_dlast), 32'd0);
      chk_val("rst_frame_err", 32'(frame_err), 32'd0);
      reset = 1'b0;
      @(posedge aclk);
      #1;
      chk_val("post_rst_s_dready", 32'(s_dready), 32'd1);

      // Single frame, both CP_LEN=4 and CP_LEN=0 instances
      m_dready = 1'b1;
      clear_mon();
      push_frame(32'h0, FFT_LEN, 1'b1);
      hs = cyc;
      wait_out(FFT_LEN + CP_LEN, 200);
      chk_val("latency", 32'(first_v - hs), 32'd2);
      add_exp(32'h0, 1'b0);
      add_exp(32'h0, 1'b1);
      repeat (5) @(posedge aclk);
      #2;
      cmp_q("single", oq, lq, eq, el);
      cmp_q("cp0", oq0, lq0, eq0, el0);

      // Three back-to-back frames
      clear_mon();
      push_frame(32'h100, FFT_LEN, 1'b1);
      push_frame(32'h200, FFT_LEN, 1'b1);
      push_frame(32'h300, FFT_LEN, 1'b1);
      wait_out(3 * (FFT_LEN + CP_LEN), 400);
      add_exp(32'h100, 1'b0);
      add_exp(32'h200, 1'b0);
      add_exp(32'h300, 1'b0);
      repeat (5) @(posedge aclk);
      #2;
      cmp_q("b2b", oq, lq, eq, el);
      chk_val("b2b_backpressure", 32'(saw_bp), 32'd1);
      chk_val("b2b_contiguous", 32'(last_x - first_x), 32'(3 * (FFT_LEN + CP_LEN) - 1));

      // Random downstream stalls over 10 frames
      clear_mon();
      done = 1'b0;
      fork
         begin
            for (int f = 0; f < 10; f++) push_frame(32'h1000 * 32'(f + 1), FFT_LEN, 1'b1);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge aclk);
               #1;
               m_dready = 1'($urandom_range(0, 1));
            end
         end
      join
      m_dready = 1'b1;
      wait_out(10 * (FFT_LEN + CP_LEN), 3000);
      for (int f = 0; f < 10; f++) add_exp(32'h1000 * 32'(f + 1), 1'b0);
      repeat (5) @(posedge aclk);
      #2;
      cmp_q("rand", oq, lq, eq, el);

      // Early s_dlast, then a good frame
      clear_mon();
      push_frame(32'h400, 10, 1'b1);
      push_frame(32'h400, FFT_LEN, 1'b1);
      wait_out(FFT_LEN + CP_LEN, 200);
      repeat (20) @(posedge aclk);
      #2;
      add_exp(32'h400, 1'b0);
      chk_val("early_err_cnt", 32'(err_cnt), 32'd1);
      cmp_q("early", oq, lq, eq, el);

      // Missing s_dlast: frame kept, error flagged
      clear_mon();
      push_frame(32'h480, FFT_LEN, 1'b0);
      wait_out(FFT_LEN + CP_LEN, 200);
      repeat (5) @(posedge aclk);
      #2;
      add_exp(32'h480, 1'b0);
      chk_val("nolast_err_cnt", 32'(err_cnt), 32'd1);
      cmp_q("nolast", oq, lq, eq, el);

      // Reset mid-playout with the second buffer full
      clear_mon();
      m_dready = 1'b0;
      push_frame(32'h500, FFT_LEN, 1'b1);
      push_frame(32'h600, FFT_LEN, 1'b1);
      m_dready = 1'b1;
      t = 0;
      while (oq.size() < 7 && t < 200) begin
         @(posedge aclk);
         #2;
         t++;
      end
      chk_val("pre_rst_count", 32'(oq.size()), 32'd7);
      reset    = 1'b1;
      m_dready = 1'b0;
      @(posedge aclk);
      #1;
      chk_val("mid_rst_m_dvalid", 32'(m_dvalid), 32'd0);
      chk_val("mid_rst_m_data", m_data_out, 32'd0);
      chk_val("mid_rst_m_dlast", 32'(m_dlast), 32'd0);
      chk_val("mid_rst_s_dready", 32'(s_dready), 32'd0);
      reset    = 1'b0;
      m_dready = 1'b1;
      clear_mon();
      repeat (30) @(posedge aclk);
      #2;
      chk_val("no_stale", 32'(oq.size()), 32'd0);
      chk_val("no_stale_cp0", 32'(oq0.size()), 32'd0);
      push_frame(32'h700, FFT_LEN, 1'b1);
      wait_out(FFT_LEN + CP_LEN, 200);
      repeat (5) @(posedge aclk);
      #2;
      add_exp(32'h700, 1'b0);
      add_exp(32'h700, 1'b1);
      cmp_q("after_rst", oq, lq, eq, el);
      cmp_q("after_rst_cp0", oq0, lq0, eq0, el0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
